delay_commutator_stage: RTL and testbench
=========================================

DELAY_COMMUTATOR_STAGE -- requirements
Module: delay_commutator_stage

Interface
REQ-001 Parameter: WIDTH, default 9, signed sample width of every re/im port.
REQ-002 Parameter: DEPTH, default 2, delay depth D; power of two in 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  input sample pair present this cycle.
REQ-006 frame_start  input  1  restart sample indexing; qualified by in_valid.
REQ-007 inUI_re, inUI_im  input  WIDTH each  upper-lane input sample u[n], signed.
REQ-008 inLI_re, inLI_im  input  WIDTH each  lower-lane input sample l[n], signed.
REQ-009 out_valid  output  1  output pair valid this cycle.
REQ-010 Up_out_re, Up_out_im  output  WIDTH each  upper output, signed, registered.
REQ-011 Low_out_re, Low_out_im  output  WIDTH each  lower output, signed, registered.
REQ-012 sel_out  output  1  current switch state, registered.

Function
REQ-013 Sample index n increments by 1 on each in_valid cycle and wraps modulo 2D; sel = n bit log2(D) (upper half of the 2D period -> sel=1).
REQ-014 Lower delay line LD: D-entry shift register; it advances only on in_valid and supplies l' = l[n-D].
REQ-015 Switch: sel=0 -> A=u[n], B=l'; sel=1 -> A=l', B=u[n].
REQ-016 Upper post-delay UD: D-entry shift register on A; it advances only on in_valid; Up_out = A[n-D], Low_out = B.
REQ-017 Outputs, out_valid and sel_out update one clock after an accepted sample; data outputs hold their last value when in_valid=0.
REQ-018 A primed flag is set after D accepted samples since reset or frame_start; out_valid = registered (in_valid AND primed).
REQ-019 in_valid=0 -> no state change, out_valid=0 next cycle (stall transparent to data order).
REQ-020 frame_start with in_valid -> the current sample takes index n=0 and primed clears. Delay contents are retained, but out_valid stays 0 for the next D accepted samples, including this one.
REQ-021 frame_start without in_valid is ignored.
REQ-022 No arithmetic is performed: values pass bit-exact, including -2^(WIDTH-1).

Reset
REQ-023 rst=1 on a clock edge clears n, primed, out_valid, sel_out, all LD/UD entries and all data outputs to 0. It takes priority over in_valid and frame_start.
REQ-024 The first accepted sample after rst deasserts has index n=0.

Configuration
REQ-025 Macro COMM_BYPASS_EN. When defined, it adds the input bypass (1 bit).
REQ-026 With COMM_BYPASS_EN defined and bypass=1: Up_out=inUI and Low_out=inLI, registered one cycle; out_valid = registered in_valid. n, primed and the delay lines hold.
REQ-027 With COMM_BYPASS_EN defined and bypass=0, or with COMM_BYPASS_EN undefined (no bypass port), behaviour is REQ-013..REQ-022.

Verification (WIDTH=9, DEPTH=2, im = -re unless stated)
REQ-028 Continuous valid, UI re = 1..6, LI re = 11..16 -> first four valid Up/Low re pairs: (1,3), (2,4), (11,13), (12,14); out_valid first high 3 clocks after the first sample.
REQ-029 Same stimulus with in_valid deasserted on alternate cycles -> identical pair sequence; out_valid high only on cycles following accepted samples.
REQ-030 frame_start on the 4th sample of a continuous stream -> out_valid low for 2 accepted samples, then pairs resume using index 0 at the restart point.
REQ-031 rst pulsed for one cycle mid-stream -> all outputs read 0 on the next cycle, out_valid=0, and the first post-reset valid pair equals the REQ-028 pattern.
REQ-032 Inputs re=-256, im=255 on both lanes -> outputs carry exactly -256/255 with no saturation or sign error.
REQ-033 COMM_BYPASS_EN defined, bypass=1, UI re=7, LI re=9 -> next cycle Up_out_re=7, Low_out_re=9, out_valid=1; after bypass returns to 0, the stream continues from the held index.

Source files
------------

// File: rtl/delay_commutator_stage.sv
// Delay-commutator stage: lower-lane delay D, lane swap on index bit log2(D), upper post-delay D.
// Latency: one clock from an accepted sample to registered outputs (plus D samples of pipeline fill).
// Backpressure: none; in_valid=0 freezes all state. Optional COMM_BYPASS_EN adds a bypass input.
module delay_commutator_stage #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    frame_start,
`ifdef COMM_BYPASS_EN
  input  logic                    bypass,
`endif
  input  logic signed [WIDTH-1:0] inUI_re,
  input  logic signed [WIDTH-1:0] inUI_im,
  input  logic signed [WIDTH-1:0] inLI_re,
  input  logic signed [WIDTH-1:0] inLI_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] Up_out_re,
  output logic signed [WIDTH-1:0] Up_out_im,
  output logic signed [WIDTH-1:0] Low_out_re,
  output logic signed [WIDTH-1:0] Low_out_im,
  output logic                    sel_out
);

  // Index spans 2D samples; the switch bit is bit log2(D) of the index.
  localparam int LB = $clog2(DEPTH);
  localparam int NW = LB + 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [2*WIDTH-1:0] cplx_t;

  logic [NW-1:0] n_q, n_d;
  logic [CW-1:0] cnt_q, cnt_d;
  cplx_t         ld_q [DEPTH];
  cplx_t         ld_d [DEPTH];
  cplx_t         ud_q [DEPTH];
  cplx_t         ud_d [DEPTH];
  cplx_t         up_q, up_d;
  cplx_t         low_q, low_d;
  logic          vld_q, vld_d;
  logic          sel_q, sel_d;

  logic          byp;
  logic [NW-1:0] idx;
  logic [CW-1:0] cur_cnt;
  logic          sel;
  cplx_t         lp, a, b;

`ifdef COMM_BYPASS_EN
  assign byp = bypass;
`else
  assign byp = 1'b0;
`endif

  // Next-state: bypass passes inputs straight through; otherwise delay, swap, delay.
  always_comb begin
    n_d     = n_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    ud_d    = ud_q;
    up_d    = up_q;
    low_d   = low_q;
    vld_d   = 1'b0;
    sel_d   = sel_q;
    idx     = frame_start ? '0 : n_q;
    cur_cnt = frame_start ? '0 : cnt_q;
    sel     = idx[LB];
    lp      = ld_q[DEPTH-1];
    a       = sel ? lp : {inUI_re, inUI_im};
    b       = sel ? {inUI_re, inUI_im} : lp;
    if (byp) begin
      if (in_valid) begin
        up_d  = {inUI_re, inUI_im};
        low_d = {inLI_re, inLI_im};
        vld_d = 1'b1;
      end
    end else if (in_valid) begin
      up_d  = ud_q[DEPTH-1];
      low_d = b;
      for (int i = DEPTH - 1; i > 0; i--) begin
        ld_d[i] = ld_q[i-1];
        ud_d[i] = ud_q[i-1];
      end
      ld_d[0] = {inLI_re, inLI_im};
      ud_d[0] = a;
      n_d     = idx + NW'(1);
      // Saturating fill count: the stage is primed once D samples have entered.
      cnt_d   = (cur_cnt == CW'(DEPTH)) ? cur_cnt : cur_cnt + CW'(1);
      vld_d   = (cur_cnt == CW'(DEPTH));
      sel_d   = sel;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q   <= '0;
      cnt_q <= '0;
      up_q  <= '0;
      low_q <= '0;
      vld_q <= 1'b0;
      sel_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ld_q[i] <= '0;
        ud_q[i] <= '0;
      end
    end else begin
      n_q   <= n_d;
      cnt_q <= cnt_d;
      up_q  <= up_d;
      low_q <= low_d;
      vld_q <= vld_d;
      sel_q <= sel_d;
      ld_q  <= ld_d;
      ud_q  <= ud_d;
    end
  end

  assign out_valid  = vld_q;
  assign sel_out    = sel_q;
  assign Up_out_re  = up_q[2*WIDTH-1:WIDTH];
  assign Up_out_im  = up_q[WIDTH-1:0];
  assign Low_out_re = low_q[2*WIDTH-1:WIDTH];
  assign Low_out_im = low_q[WIDTH-1:0];

endmodule

// File: tb/tb_delay_commutator_stage.sv
// Testbench for delay_commutator_stage: queue-based reference model plus literal pins.
// Latency: model predicts outputs one clock after each driven cycle.
// Backpressure: stalls and frame restarts exercised with directed vectors.
module tb_delay_commutator_stage;
  localparam int W = 9;
  localparam int D = 2;

  typedef logic [2*W-1:0] cplx_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic frame_start = 1'b0;
  logic bypass = 1'b0;
  logic signed [W-1:0] inUI_re = '0, inUI_im = '0, inLI_re = '0, inLI_im = '0;
  logic out_valid, sel_out;
  logic signed [W-1:0] Up_out_re, Up_out_im, Low_out_re, Low_out_im;

  delay_commutator_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
`ifdef COMM_BYPASS_EN
    .bypass(bypass),
`endif
    .inUI_re(inUI_re), .inUI_im(inUI_im), .inLI_re(inLI_re), .inLI_im(inLI_im),
    .out_valid(out_valid), .Up_out_re(Up_out_re), .Up_out_im(Up_out_im),
    .Low_out_re(Low_out_re), .Low_out_im(Low_out_im), .sel_out(sel_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int re_of(input cplx_t c);
    logic signed [W-1:0] t;
    t = c[2*W-1:W];
    return int'(t);
  endfunction

  function automatic int im_of(input cplx_t c);
    logic signed [W-1:0] t;
    t = c[W-1:0];
    return int'(t);
  endfunction

  // Reference model: history queues of the last D lower samples and D switch-A values.
  cplx_t lq[$];
  cplx_t aq[$];
  int    m_n, m_cnt;
  cplx_t m_up, m_low;
  logic  m_vld, m_sel;
  cplx_t exp_up, exp_low;
  logic  exp_vld, exp_sel;
  logic  chk_en = 1'b0;

  int cap_ur[$], cap_ui[$], cap_lr[$], cap_li[$];

  task automatic model(input logic r, input logic v, input logic fs, input logic bp,
                       input cplx_t u, input cplx_t l);
    cplx_t lp, a, b;
    logic  s;
    if (r) begin
      lq.delete(); aq.delete();
      for (int i = 0; i < D; i++) begin lq.push_back('0); aq.push_back('0); end
      m_n = 0; m_cnt = 0; m_up = '0; m_low = '0; m_vld = 1'b0; m_sel = 1'b0;
    end else if (bp) begin
      m_vld = v;
      if (v) begin m_up = u; m_low = l; end
    end else if (v) begin
      if (fs) begin m_n = 0; m_cnt = 0; end
      s  = ((m_n % (2 * D)) >= D);
      lp = lq.pop_front();
      lq.push_back(l);
      a  = s ? lp : u;
      b  = s ? u : lp;
      m_up  = aq.pop_front();
      aq.push_back(a);
      m_low = b;
      m_vld = (m_cnt >= D);
      m_sel = s;
      m_cnt++;
      m_n = (m_n + 1) % (2 * D);
    end else begin
      m_vld = 1'b0;
    end
  endtask

  task automatic step(input logic r, input logic v, input logic fs, input logic bp,
                      input int ure, input int uim, input int lre, input int lim);
    logic [W-1:0] a1, a2, a3, a4;
    a1 = ure[W-1:0]; a2 = uim[W-1:0]; a3 = lre[W-1:0]; a4 = lim[W-1:0];
    rst = r; in_valid = v; frame_start = fs; bypass = bp;
    inUI_re = a1; inUI_im = a2; inLI_re = a3; inLI_im = a4;
    model(r, v, fs, bp, {a1, a2}, {a3, a4});
    @(posedge clk);
    #1;
    exp_up = m_up; exp_low = m_low; exp_vld = m_vld; exp_sel = m_sel;
    chk_en = 1'b1;
  endtask

  task automatic sample(input int k);
    step(0, 1, 0, 0, k, -k, 10 + k, -(10 + k));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic clear_cap();
    cap_ur.delete(); cap_ui.delete(); cap_lr.delete(); cap_li.delete();
  endtask

  task automatic check_pairs(input string nm, input int eu[4], input int el[4]);
    chk({nm, " count"}, int'(cap_ur.size() >= 4), 1);
    for (int i = 0; i < 4; i++) begin
      if (i < cap_ur.size()) begin
        chk($sformatf("%s up_re[%0d]", nm, i), cap_ur[i], eu[i]);
        chk($sformatf("%s low_re[%0d]", nm, i), cap_lr[i], el[i]);
        chk($sformatf("%s up_im[%0d]", nm, i), cap_ui[i], -eu[i]);
      end
    end
  endtask

  // Compare every output against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", int'(out_valid), int'(exp_vld));
      chk("sel_out", int'(sel_out), int'(exp_sel));
      chk("up_re", int'(Up_out_re), re_of(exp_up));
      chk("up_im", int'(Up_out_im), im_of(exp_up));
      chk("low_re", int'(Low_out_re), re_of(exp_low));
      chk("low_im", int'(Low_out_im), im_of(exp_low));
      if (out_valid) begin
        cap_ur.push_back(int'(Up_out_re)); cap_ui.push_back(int'(Up_out_im));
        cap_lr.push_back(int'(Low_out_re)); cap_li.push_back(int'(Low_out_im));
      end
    end
  end

  initial begin
    int eu[4];
    int el[4];
    eu = '{1, 2, 11, 12};
    el = '{3, 4, 13, 14};

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset up_re", int'(Up_out_re), 0);
    chk("reset low_im", int'(Low_out_im), 0);

    // Continuous stream: valid first appears after the third sample.
    clear_cap();
    sample(1); chk("latency s1", int'(out_valid), 0);
    sample(2); chk("latency s2", int'(out_valid), 0);
    sample(3); chk("latency s3", int'(out_valid), 1);
    for (int k = 4; k <= 6; k++) sample(k);
    idle(); idle();
    check_pairs("cont", eu, el);

    // Alternate-cycle stall, including an ignored frame_start on an idle cycle.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    clear_cap();
    for (int k = 1; k <= 6; k++) begin
      sample(k);
      if (k == 3) step(0, 0, 1, 0, 0, 0, 0, 0);
      else idle();
      chk("stall gap", int'(out_valid), 0);
    end
    check_pairs("stall", eu, el);

    // frame_start on the 4th sample restarts indexing and refills.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    clear_cap();
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, (k == 4), 0, k, -k, 10 + k, -(10 + k));
      if (k == 4 || k == 5) chk("restart fill", int'(out_valid), 0);
    end
    idle();
    begin
      int fu[4];
      int fl[4];
      fu = '{1, 4, 5, 14};
      fl = '{3, 6, 7, 16};
      check_pairs("restart", fu, fl);
    end

    // Reset mid-stream, with valid and frame_start asserted alongside it.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) sample(k);
    step(1, 1, 1, 0, 5, -5, 15, -15);
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst up_re", int'(Up_out_re), 0);
    chk("mid rst low_re", int'(Low_out_re), 0);
    chk("mid rst sel", int'(sel_out), 0);
    clear_cap();
    for (int k = 1; k <= 6; k++) sample(k);
    idle();
    check_pairs("post rst", eu, el);

    // Most-negative value passes bit-exact.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    clear_cap();
    for (int k = 1; k <= 6; k++) step(0, 1, 0, 0, -256, 255, -256, 255);
    idle();
    chk("extreme count", int'(cap_ur.size()), 4);
    for (int i = 0; i < cap_ur.size(); i++) begin
      chk("extreme up_re", cap_ur[i], -256);
      chk("extreme up_im", cap_ui[i], 255);
      chk("extreme low_re", cap_lr[i], -256);
      chk("extreme low_im", cap_li[i], 255);
    end

`ifdef COMM_BYPASS_EN
    // Bypass passes inputs through and leaves the stream state untouched.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) sample(k);
    step(0, 1, 0, 1, 7, -7, 9, -9);
    chk("bypass up_re", int'(Up_out_re), 7);
    chk("bypass low_re", int'(Low_out_re), 9);
    chk("bypass out_valid", int'(out_valid), 1);
    for (int k = 4; k <= 6; k++) sample(k);
    idle();
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
